// File: rtl/phy_rx_destripe.sv
// phy_rx_destripe: receive-side 4-lane de-striper.
// A COM framing symbol sets the lane-0 boundary. Valid non-COM bytes are then
// distributed round-robin into lanes 0..3. Each completed group is presented
// on Out0..Out3 with a one-cycle valid pulse. A partial group that is broken
// by a COM or by an over-long idle gap is dropped, and align_err pulses.
//
// Ports:
//   clk, reset        clock; asynchronous active-high reset
//   data_in/valid_in  serial byte stream from the PHY
//   Out0..Out3        de-striped lane bytes (held while valid* = 0)
//   valid0..valid3    one-cycle pulse per completed group (all four equal)
//   aligned           1 while in the ALIGNED state
//   align_err         one-cycle pulse on a framing error
//   rx_groups, err_count  statistics counters, present only when
//                     PHY_RX_STATS_EN is defined
//
// Optional feature macro: PHY_RX_STATS_EN

// Per-lane storage. A byte is buffered as it arrives. On commit it is copied
// to the lane output. The lane that receives the group's last byte takes it
// straight from din, because that byte arrives on the commit edge itself.
module phy_rx_lane #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              store,
  input  logic              commit,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout
);
  logic [DATA_W-1:0] hold;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold <= '0;
      dout <= '0;
    end else begin
      if (store)  hold <= din;
      if (commit) dout <= store ? din : hold;
    end
  end
endmodule

module phy_rx_destripe #(
  parameter int              DATA_W  = 8,
  parameter logic [DATA_W-1:0] COM_SYM = 8'hBC,
  parameter int              MAX_GAP = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] data_in,
  input  logic              valid_in,
  output logic [DATA_W-1:0] Out0,
  output logic [DATA_W-1:0] Out1,
  output logic [DATA_W-1:0] Out2,
  output logic [DATA_W-1:0] Out3,
  output logic              valid0,
  output logic              valid1,
  output logic              valid2,
  output logic              valid3,
  output logic              aligned,
`ifdef PHY_RX_STATS_EN
  output logic [15:0]       rx_groups,
  output logic [7:0]        err_count,
`endif
  output logic              align_err
);
  localparam int NUM_LANES = 4;
  localparam int IDX_W     = 2;
  localparam int GAP_W     = $clog2(MAX_GAP + 1);

  typedef enum logic {SEARCH, ALIGNED} state_t;

  state_t            state, state_n;
  logic [IDX_W-1:0]  idx, idx_n;
  logic [GAP_W-1:0]  gap_cnt, gap_n, gap_inc;
  logic              err_n, commit, take;
  logic              vld;
  logic [NUM_LANES-1:0][DATA_W-1:0] lane_out;

  wire is_com = valid_in && (data_in == COM_SYM);
  assign gap_inc = gap_cnt + GAP_W'(1);

  always_comb begin
    state_n = state;
    idx_n   = idx;
    gap_n   = '0;
    err_n   = 1'b0;
    commit  = 1'b0;
    take    = 1'b0;
    case (state)
      SEARCH: begin
        idx_n = '0;
        if (is_com) state_n = ALIGNED;
      end
      ALIGNED: begin
        if (valid_in && !is_com) begin
          // A valid byte always clears the gap counter. This covers the cycle
          // on which the counter would otherwise have reached MAX_GAP.
          take = 1'b1;
          if (idx == IDX_W'(NUM_LANES - 1)) begin
            commit = 1'b1;
            idx_n  = '0;
          end else begin
            idx_n = idx + IDX_W'(1);
          end
        end else if (is_com) begin
          // A COM at a group boundary is a harmless skip. Mid-group, it drops
          // the partial group.
          err_n = (idx != '0);
          idx_n = '0;
        end else if (idx != '0) begin
          if (gap_inc == GAP_W'(MAX_GAP)) begin
            err_n   = 1'b1;
            idx_n   = '0;
            state_n = SEARCH;
          end else begin
            gap_n = gap_inc;
          end
        end
      end
      default: state_n = SEARCH;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= SEARCH;
      idx       <= '0;
      gap_cnt   <= '0;
      vld       <= 1'b0;
      align_err <= 1'b0;
    end else begin
      state     <= state_n;
      idx       <= idx_n;
      gap_cnt   <= gap_n;
      vld       <= commit;
      align_err <= err_n;
    end
  end

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    phy_rx_lane #(.DATA_W(DATA_W)) u_lane (
      .clk    (clk),
      .reset  (reset),
      .store  (take && (idx == IDX_W'(i))),
      .commit (commit),
      .din    (data_in),
      .dout   (lane_out[i])
    );
  end

  assign Out0    = lane_out[0];
  assign Out1    = lane_out[1];
  assign Out2    = lane_out[2];
  assign Out3    = lane_out[3];
  assign valid0  = vld;
  assign valid1  = vld;
  assign valid2  = vld;
  assign valid3  = vld;
  assign aligned = (state == ALIGNED);

`ifdef PHY_RX_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_groups <= '0;
      err_count <= '0;
    end else begin
      if (vld) rx_groups <= rx_groups + 16'd1;
      if (align_err && err_count != 8'hFF) err_count <= err_count + 8'd1;
    end
  end
`endif
endmodule
